mad_io_port: RTL and testbench
==============================

# mad_io_port

Host-side I/O responder for `mad_risc_processor`. It feeds the processor's 16-bit `In` port from a small input FIFO loaded by the host or testbench. It captures words the processor writes on `Out` into an output FIFO drained by the host. It raises the processor's `Int` line when new input arrives. It replaces hand-driven `In`/`Int` stimulus with a buffered, handshaken port.

## Interface

Parameters:
- `WIDTH`, 16: data word width; matches processor `In`/`Out`.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.

Ports:
- `Clk` in 1: the only clock; all state updates on its rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `HostInData` in WIDTH: word offered to the input FIFO.
- `HostInValid` in 1: host offers `HostInData` this cycle.
- `HostInReady` out 1: input FIFO not full. A push happens when `HostInValid & HostInReady`.
- `CpuIn` out WIDTH: head of the input FIFO; 0 when empty. Connects to processor `In`.
- `CpuInRd` in 1: processor consumes the head word this cycle.
- `CpuOut` in WIDTH: processor `Out` value.
- `CpuOutWr` in 1: processor writes `CpuOut` this cycle.
- `HostOutData` out WIDTH: head of the output FIFO; 0 when empty.
- `HostOutValid` out 1: output FIFO not empty.
- `HostOutRd` in 1: host pops the output head. Ignored when `HostOutValid` is 0.
- `Int` out 1: interrupt pulse to processor `Int`.
- `InUnderflow` out 1: sticky; `CpuInRd` seen while the input FIFO was empty.
- `OutOverflow` out 1: sticky; a `CpuOutWr` word was dropped.

## Operation

- Each FIFO is a circular buffer with read pointer, write pointer, and count (0..DEPTH).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count has one extra bit to hold DEPTH.
- Input FIFO:
  - Push when `HostInValid & HostInReady`. `HostInReady = (in_count != DEPTH)`, derived from registered state only.
  - Pop when `CpuInRd & (in_count != 0)`. A `CpuInRd` on empty changes no state and sets `InUnderflow`.
  - Simultaneous push and pop: both take effect; count is unchanged.
  - When full, `HostInReady` is 0 even if `CpuInRd` is high that cycle. No pass-through.
- Output FIFO:
  - Write when `CpuOutWr` and the FIFO is not full, or when it is full and `HostOutRd` is high the same cycle. In that case pop and push both occur and count stays DEPTH.
  - Otherwise a `CpuOutWr` on full drops the word and sets `OutOverflow`.
  - `HostOutRd` with `HostOutValid` low is ignored and sets no flag.
- Interrupt FSM, states IDLE and PULSE:
  - IDLE → PULSE when a push is accepted while `in_count == 0`. Any pop in the same cycle is impossible, since the FIFO is empty.
  - PULSE → IDLE unconditionally after one cycle.
  - `Int` = (state == PULSE).
  - Pushes into a non-empty FIFO do not interrupt. The FIFO draining to empty re-arms the trigger.
- Sticky flags clear only on `Rst`.
- Data is passed unmodified. No width conversion.

## Timing

- Reset values: all pointers and counts 0; FSM IDLE.
  - Outputs: `CpuIn`=0, `HostOutData`=0, `HostOutValid`=0, `HostInReady`=1, `Int`=0, `InUnderflow`=0, `OutOverflow`=0.
  - `Rst` overrides every same-cycle push, pop, or write. FIFO contents are discarded mid-operation.
- Input latency: a word pushed at edge N appears on `CpuIn` after edge N, i.e. in cycle N+1. `Int` is high in that same cycle N+1 for exactly one cycle.
- Output latency: a word written at edge N appears on `HostOutData` with `HostOutValid`=1 in cycle N+1.
- After a pop, the next head appears in the following cycle. `CpuIn` and `HostOutData` are driven from storage at the read pointer, muxed to 0 when empty. No registered output stage.
- Sticky flags assert in the cycle after the offending edge.

## Test plan

- Reset, then push 0x0005 → next cycle `CpuIn`=0x0005 and `Int`=1 for one cycle only. `HostInReady` stays 1.
- Push 0x0005, 0xFFFF, 0xF320, 0xAABD back-to-back → `HostInReady`=0 after the fourth, and `Int` pulses once only. A fifth push of 0x1234 is rejected. `CpuInRd` on four consecutive cycles yields 0x0005, 0xFFFF, 0xF320, 0xAABD, then `CpuIn`=0.
- Drain to empty, push 0x00AA → `Int` pulses again. Issuing `CpuInRd` while empty sets `InUnderflow`=1, and it holds until `Rst`.
- `CpuOutWr` with 0x0011, 0x0022 → `HostOutValid`=1 and `HostOutData`=0x0011; after `HostOutRd` it shows 0x0022; after a second read `HostOutValid`=0.
- Fill the output FIFO with 4 writes, then a fifth write 0x0055 with `HostOutRd`=0 → dropped and `OutOverflow`=1. Repeat with `HostOutRd`=1 → accepted, count stays 4, and the last entry read out is 0x0055.
- Wrap-around with `DEPTH`=4: do 10 interleaved push/pop pairs with simultaneous push and pop → order is preserved and the count is unchanged. Then assert `Rst` mid-stream → every output returns to its reset value the next cycle.

Source files
------------

// File: rtl/mad_io_port.sv
// rtl/mad_io_port.sv - buffered host/processor I/O port with input-arrival interrupt
module mad_io_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] HostInData,
  input  logic             HostInValid,
  output logic             HostInReady,
  output logic [WIDTH-1:0] CpuIn,
  input  logic             CpuInRd,
  input  logic [WIDTH-1:0] CpuOut,
  input  logic             CpuOutWr,
  output logic [WIDTH-1:0] HostOutData,
  output logic             HostOutValid,
  input  logic             HostOutRd,
  output logic             Int,
  output logic             InUnderflow,
  output logic             OutOverflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, PULSE} int_state_e;

  logic [WIDTH-1:0] in_mem_q  [DEPTH];
  logic [WIDTH-1:0] out_mem_q [DEPTH];
  logic [AW-1:0]    in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [AW-1:0]    out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic             in_uf_q, in_uf_d, out_of_q, out_of_d;
  int_state_e       state_q, state_d;

  logic in_empty, in_push, in_pop;
  logic out_empty, out_full, out_push, out_pop;

  assign in_empty    = (in_cnt_q == '0);
  assign HostInReady = (in_cnt_q != FULL_CNT);
  assign in_push     = HostInValid & HostInReady;
  assign in_pop      = CpuInRd & ~in_empty;

  // A write into a full output FIFO is still taken when the host frees a slot that same cycle.
  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign out_pop   = HostOutRd & ~out_empty;
  assign out_push  = CpuOutWr & (~out_full | HostOutRd);

  assign CpuIn        = in_empty  ? '0 : in_mem_q[in_rd_q];
  assign HostOutData  = out_empty ? '0 : out_mem_q[out_rd_q];
  assign HostOutValid = ~out_empty;
  assign InUnderflow  = in_uf_q;
  assign OutOverflow  = out_of_q;

  always_comb begin
    in_rd_d   = in_rd_q + AW'(in_pop);
    in_wr_d   = in_wr_q + AW'(in_push);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_rd_d  = out_rd_q + AW'(out_pop);
    out_wr_d  = out_wr_q + AW'(out_push);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    in_uf_d   = in_uf_q | (CpuInRd & in_empty);
    out_of_d  = out_of_q | (CpuOutWr & ~out_push);
  end

  // Interrupt only on the empty -> non-empty transition; draining to empty re-arms it.
  always_comb begin
    state_d = state_q;
    Int     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_push && in_empty) state_d = PULSE;
      end
      PULSE: begin
        Int     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_cnt_q  <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      in_uf_q   <= 1'b0;
      out_of_q  <= 1'b0;
      state_q   <= IDLE;
    end else begin
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      in_uf_q   <= in_uf_d;
      out_of_q  <= out_of_d;
      state_q   <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && in_push)  in_mem_q[in_wr_q]   <= HostInData;
    if (!Rst && out_push) out_mem_q[out_wr_q] <= CpuOut;
  end

endmodule

// File: tb/tb_mad_io_port.sv
// tb/tb_mad_io_port.sv - self-checking bench for mad_io_port against a queue-based model
module tb_mad_io_port;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [WIDTH-1:0] HostInData = '0;
  logic             HostInValid = 1'b0;
  logic             HostInReady;
  logic [WIDTH-1:0] CpuIn;
  logic             CpuInRd = 1'b0;
  logic [WIDTH-1:0] CpuOut = '0;
  logic             CpuOutWr = 1'b0;
  logic [WIDTH-1:0] HostOutData;
  logic             HostOutValid;
  logic             HostOutRd = 1'b0;
  logic             Int;
  logic             InUnderflow;
  logic             OutOverflow;

  mad_io_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .HostInData(HostInData), .HostInValid(HostInValid), .HostInReady(HostInReady),
    .CpuIn(CpuIn), .CpuInRd(CpuInRd),
    .CpuOut(CpuOut), .CpuOutWr(CpuOutWr),
    .HostOutData(HostOutData), .HostOutValid(HostOutValid), .HostOutRd(HostOutRd),
    .Int(Int), .InUnderflow(InUnderflow), .OutOverflow(OutOverflow)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] m_in[$];
  logic [WIDTH-1:0] m_out[$];
  logic m_int = 1'b0, m_uf = 1'b0, m_of = 1'b0;

  // Reference model: advance queues by the current inputs, then step the DUT one edge.
  task automatic cycle();
    bit was_empty, push, opush, opop;
    if (Rst) begin
      m_in.delete(); m_out.delete();
      m_int = 1'b0; m_uf = 1'b0; m_of = 1'b0;
    end else begin
      was_empty = (m_in.size() == 0);
      push = HostInValid && (m_in.size() < DEPTH);
      if (CpuInRd && was_empty) m_uf = 1'b1;
      if (CpuInRd && !was_empty) void'(m_in.pop_front());
      if (push) m_in.push_back(HostInData);
      m_int = push && was_empty;
      opop  = HostOutRd && (m_out.size() != 0);
      opush = CpuOutWr && ((m_out.size() < DEPTH) || HostOutRd);
      if (CpuOutWr && !opush) m_of = 1'b1;
      if (opop) void'(m_out.pop_front());
      if (opush) m_out.push_back(CpuOut);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    HostInValid = 1'b0; CpuInRd = 1'b0; CpuOutWr = 1'b0; HostOutRd = 1'b0;
    HostInData = '0; CpuOut = '0;
  endtask

  task automatic do_reset();
    set_idle();
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    do_reset();
    cycle();
    got = {CpuIn, HostOutData, HostOutValid, HostInReady, Int, InUnderflow, OutOverflow};
    total_cnt++;
    if (got !== {16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values got %h expected %h", got, {16'h0, 16'h0, 5'b01000});
    else pass_cnt++;
  endtask

  task automatic test_single_push();
    HostInData = 16'h0005; HostInValid = 1'b1;
    cycle();
    HostInValid = 1'b0;
    total_cnt++;
    if (CpuIn !== 16'h0005) $display("FAIL single_cpuin got %h expected 0005", CpuIn); else pass_cnt++;
    total_cnt++;
    if (Int !== 1'b1) $display("FAIL single_int_high got %b expected 1", Int); else pass_cnt++;
    total_cnt++;
    if (HostInReady !== 1'b1) $display("FAIL single_ready got %b expected 1", HostInReady); else pass_cnt++;
    cycle();
    total_cnt++;
    if (Int !== 1'b0) $display("FAIL single_int_one_cycle got %b expected 0", Int); else pass_cnt++;
    CpuInRd = 1'b1;
    cycle();
    CpuInRd = 1'b0;
    total_cnt++;
    if (CpuIn !== 16'h0000) $display("FAIL single_pop_empty got %h expected 0000", CpuIn); else pass_cnt++;
  endtask

  task automatic test_fill_input();
    logic [WIDTH-1:0] vals [4] = '{16'h0005, 16'hFFFF, 16'hF320, 16'hAABD};
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      HostInData = vals[i]; HostInValid = 1'b1;
      cycle();
      pulses += int'(Int);
    end
    total_cnt++;
    if (HostInReady !== 1'b0) $display("FAIL fill_ready got %b expected 0", HostInReady); else pass_cnt++;
    HostInData = 16'h1234;
    cycle();
    pulses += int'(Int);
    HostInValid = 1'b0;
    total_cnt++;
    if (pulses != 1) $display("FAIL fill_int_pulses got %0d expected 1", pulses); else pass_cnt++;
    CpuInRd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (CpuIn !== vals[i]) $display("FAIL fill_read_%0d got %h expected %h", i, CpuIn, vals[i]); else pass_cnt++;
      cycle();
    end
    CpuInRd = 1'b0;
    total_cnt++;
    if ({CpuIn, InUnderflow} !== {16'h0000, 1'b0})
      $display("FAIL fill_drained got %h/%b expected 0000/0", CpuIn, InUnderflow);
    else pass_cnt++;
  endtask

  task automatic test_rearm_underflow();
    HostInData = 16'h00AA; HostInValid = 1'b1;
    cycle();
    HostInValid = 1'b0;
    total_cnt++;
    if ({Int, CpuIn} !== {1'b1, 16'h00AA}) $display("FAIL rearm_int got %b/%h expected 1/00aa", Int, CpuIn); else pass_cnt++;
    CpuInRd = 1'b1;
    cycle();
    cycle();
    CpuInRd = 1'b0;
    total_cnt++;
    if (InUnderflow !== 1'b1) $display("FAIL underflow_set got %b expected 1", InUnderflow); else pass_cnt++;
    repeat (3) cycle();
    total_cnt++;
    if (InUnderflow !== 1'b1) $display("FAIL underflow_sticky got %b expected 1", InUnderflow); else pass_cnt++;
  endtask

  task automatic test_output_basic();
    CpuOutWr = 1'b1; CpuOut = 16'h0011;
    cycle();
    CpuOut = 16'h0022;
    cycle();
    CpuOutWr = 1'b0;
    total_cnt++;
    if ({HostOutValid, HostOutData} !== {1'b1, 16'h0011})
      $display("FAIL out_head got %b/%h expected 1/0011", HostOutValid, HostOutData);
    else pass_cnt++;
    HostOutRd = 1'b1;
    cycle();
    HostOutRd = 1'b0;
    total_cnt++;
    if (HostOutData !== 16'h0022) $display("FAIL out_second got %h expected 0022", HostOutData); else pass_cnt++;
    HostOutRd = 1'b1;
    cycle();
    HostOutRd = 1'b0;
    total_cnt++;
    if ({HostOutValid, HostOutData} !== {1'b0, 16'h0000})
      $display("FAIL out_empty got %b/%h expected 0/0000", HostOutValid, HostOutData);
    else pass_cnt++;
  endtask

  task automatic test_output_overflow();
    logic [WIDTH-1:0] exp [4] = '{16'h0042, 16'h0043, 16'h0044, 16'h0055};
    CpuOutWr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CpuOut = WIDTH'(16'h0041 + i);
      cycle();
    end
    CpuOut = 16'h0055;
    cycle();
    total_cnt++;
    if ({OutOverflow, HostOutData} !== {1'b1, 16'h0041})
      $display("FAIL overflow_drop got %b/%h expected 1/0041", OutOverflow, HostOutData);
    else pass_cnt++;
    HostOutRd = 1'b1;
    cycle();
    CpuOutWr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({HostOutValid, HostOutData} !== {1'b1, exp[i]})
        $display("FAIL overflow_drain_%0d got %b/%h expected 1/%h", i, HostOutValid, HostOutData, exp[i]);
      else pass_cnt++;
      cycle();
    end
    HostOutRd = 1'b0;
    total_cnt++;
    if (HostOutValid !== 1'b0) $display("FAIL overflow_final_empty got %b expected 0", HostOutValid); else pass_cnt++;
  endtask

  task automatic test_wraparound();
    logic [WIDTH-1:0] w;
    do_reset();
    HostInData = 16'($urandom); HostInValid = 1'b1;
    cycle();
    CpuInRd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      HostInData = w;
      cycle();
      total_cnt++;
      if ({CpuIn, HostInReady, Int} !== {w, 1'b1, 1'b0})
        $display("FAIL wrap_%0d got %h/%b/%b expected %h/1/0", i, CpuIn, HostInReady, Int, w);
      else pass_cnt++;
    end
    HostInValid = 1'b0;
    cycle();
    CpuInRd = 1'b0;
    total_cnt++;
    if (CpuIn !== 16'h0000) $display("FAIL wrap_count_one got %h expected 0000", CpuIn); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [36:0] got, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Rst         = ($urandom_range(0, 59) == 0);
      HostInValid = ($urandom_range(0, 2) != 0);
      HostInData  = 16'($urandom);
      CpuInRd     = ($urandom_range(0, 2) == 0);
      CpuOutWr    = ($urandom_range(0, 1) == 1);
      CpuOut      = 16'($urandom);
      HostOutRd   = ($urandom_range(0, 2) == 0);
      cycle();
      exp = {(m_in.size() != 0) ? m_in[0] : 16'h0, (m_out.size() != 0) ? m_out[0] : 16'h0,
             m_out.size() != 0, m_in.size() != DEPTH, m_int, m_uf, m_of};
      got = {CpuIn, HostOutData, HostOutValid, HostInReady, Int, InUnderflow, OutOverflow};
      total_cnt++;
      if (got !== exp) $display("FAIL random_%0d got %h expected %h", i, got, exp); else pass_cnt++;
    end
    Rst = 1'b0;
    set_idle();
  endtask

  task automatic test_reset_midstream();
    logic [36:0] got;
    do_reset();
    CpuInRd = 1'b1;
    cycle();
    CpuInRd = 1'b0;
    HostInValid = 1'b1; HostInData = 16'h1111; CpuOutWr = 1'b1; CpuOut = 16'h2222;
    repeat (5) cycle();
    Rst = 1'b1; CpuInRd = 1'b1;
    cycle();
    Rst = 1'b0;
    set_idle();
    got = {CpuIn, HostOutData, HostOutValid, HostInReady, Int, InUnderflow, OutOverflow};
    total_cnt++;
    if (got !== {16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_midstream got %h expected %h", got, {16'h0, 16'h0, 5'b01000});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_input();
    test_rearm_underflow();
    test_output_basic();
    test_output_overflow();
    test_wraparound();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
